sqwave_seq_ctrl: RTL
====================

// Module: sqwave_seq_ctrl
// PURPOSE
//  Sequencer for square_wave_gen: holds a small table of {m, n, periods} entries and, on start,
//  drives o_m/o_n to the generator one entry at a time, counting rising edges of the generator
//  output (i_q) to decide when to advance. Sits between a host/register interface and the
//  generator; the generator itself is unchanged.
// PARAMETERS
//  DEPTH        8     table entries (power of 2, >=2)
//  CNT_W        8     width of per-entry period count
//  TIMEOUT_CYC  4096  max clocks between i_q rising edges before entry is abandoned
// PORTS
//  i_clk      in   1              system clock
//  i_rst_n    in   1              async active-low reset
//  i_wr_en    in   1              table write strobe (ignored while o_busy)
//  i_wr_addr  in   $clog2(DEPTH)  table write index
//  i_wr_m     in   4              on-time code for entry
//  i_wr_n     in   4              off-time code for entry
//  i_wr_cnt   in   CNT_W          periods to run entry (0 = skip)
//  i_start    in   1              level/pulse; starts sequence from entry 0 when idle
//  i_stop     in   1              abort; returns to IDLE next cycle
//  i_loop     in   1              sampled at wrap: 1 = restart at entry 0, 0 = finish
//  i_q        in   1              square_wave_gen output, fed back
//  o_m        out  4              to generator i_m
//  o_n        out  4              to generator i_n
//  o_busy     out  1              high in LOAD/RUN
//  o_idx      out  $clog2(DEPTH)  current entry index
//  o_done     out  1              1-cycle pulse on normal completion
//  o_err      out  1              sticky: timeout or pass with no applied entry; clears on start
// BEHAVIOUR
//  - Reset: state IDLE, o_m=o_n=0, o_busy=0, o_idx=0, o_done=0, o_err=0, table cleared to 0.
//  - Table write: registered, visible from next cycle; dropped entirely when o_busy=1.
//  - States: IDLE -> LOAD -> RUN -> (LOAD | DONE) ; DONE -> IDLE after 1 cycle.
//  - IDLE: o_m=o_n=0. i_start=1 & i_stop=0 -> LOAD, idx=0, o_err cleared. i_stop wins over i_start.
//  - LOAD (1 cycle): if entry.cnt==0 -> advance idx without applying (o_m/o_n unchanged);
//    else o_m/o_n <= entry m/n (visible cycle after LOAD), period counter=0, timer=0, -> RUN.
//  - RUN: edge = i_q & ~q_d (q_d registered i_q, reset 0; q_d initialised to current i_q on
//    LOAD so a level already high does not count). Each edge: counter++, timer=0.
//    counter reaches entry.cnt -> advance. timer reaches TIMEOUT_CYC-1 -> set o_err, advance.
//  - Advance: idx<DEPTH-1 -> idx+1, LOAD. idx==DEPTH-1 (wrap): if pass applied >=1 entry
//    and i_loop -> idx=0, LOAD; else -> DONE (o_err set if zero entries applied).
//  - DONE: o_done=1 one cycle, o_m=o_n=0 from next cycle, -> IDLE.
//  - i_stop in LOAD/RUN/DONE: -> IDLE next cycle, o_m=o_n=0, no o_done, o_err kept.
//  - Reset mid-run: immediate return to reset values (async).
//  - Counters: period counter CNT_W bits, never wraps (compare before increment);
//    timer $clog2(TIMEOUT_CYC) bits.
// STRUCTURE
//  - sqwave_seq_pkg: state_t enum {IDLE,LOAD,RUN,DONE}; entry_t packed struct {m[3:0],
//    n[3:0], cnt[CNT_W-1:0]}.
//  - Sub-module sqwave_period_cnt: edge detect on i_q, period counter, timeout timer;
//    inputs clear/target, outputs hit/timeout.
//  - Top: table (array of entry_t), FSM, output registers.
// TESTING (bench instantiates square_wave_gen with o_m/o_n/i_q looped back)
//  - Write e0={1,1,3}, e1={5,5,2}, rest cnt=0, start, loop=0 -> 3 periods @1/1, 2 @5/5,
//    skips e2..e7, o_done once, o_err=0, o_m=o_n=0 after.
//  - Same table, loop=1 -> o_idx returns to 0 after wrap; i_stop mid e1 -> IDLE next cycle, no o_done.
//  - e0={0,0,2} (generator stuck) with TIMEOUT_CYC=64 -> advance after 64 clocks, o_err=1;
//    next start clears o_err.
//  - All entries cnt=0, start -> DONE after 8 LOAD cycles with o_err=1.
//  - i_wr_en to running idx while busy -> table unchanged (re-run shows old values).
//  - Assert i_rst_n low during RUN -> all outputs at reset values same cycle; i_start+i_stop together -> stays IDLE.

Source files
------------

// File: rtl/sqwave_seq_pkg.sv
// Shared types for the square-wave sequencer: FSM states and table entry layout.
package sqwave_seq_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned MN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [MN_W-1:0]  m;
    logic [MN_W-1:0]  n;
    logic [CNT_W-1:0] cnt;
  } entry_t;

endpackage

// File: rtl/sqwave_seq_ctrl_if.sv
// Host/generator-facing signal bundle of the square-wave sequencer.
interface sqwave_seq_ctrl_if #(
  parameter int unsigned DEPTH = 8
);
  import sqwave_seq_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic             i_wr_en;
  logic [AW-1:0]    i_wr_addr;
  logic [MN_W-1:0]  i_wr_m;
  logic [MN_W-1:0]  i_wr_n;
  logic [CNT_W-1:0] i_wr_cnt;
  logic             i_start;
  logic             i_stop;
  logic             i_loop;
  logic             i_q;
  logic [MN_W-1:0]  o_m;
  logic [MN_W-1:0]  o_n;
  logic             o_busy;
  logic [AW-1:0]    o_idx;
  logic             o_done;
  logic             o_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_m, i_wr_n, i_wr_cnt,
    output i_start, i_stop, i_loop, i_q,
    input  o_m, o_n, o_busy, o_idx, o_done, o_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_m, i_wr_n, i_wr_cnt,
    input  i_start, i_stop, i_loop, i_q,
    output o_m, o_n, o_busy, o_idx, o_done, o_err
  );

endinterface

// File: rtl/sqwave_period_cnt.sv
// Counts rising edges of the generator output for one entry and flags target hit or edge timeout.
module sqwave_period_cnt
  import sqwave_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_q,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_hit_c,
  output logic             o_timeout_c
);

  localparam int unsigned          TIMER_W   = $clog2(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0]   TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

  logic               q_d;
  logic               rise_c;
  logic [CNT_W-1:0]   cnt;
  logic [TIMER_W-1:0] timer;

  // q_d follows i_q every cycle, so a level already high at LOAD is not an edge
  assign rise_c = i_q & ~q_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_d   <= 1'b0;
      cnt   <= '0;
      timer <= '0;
    end else begin
      q_d <= i_q;
      if (i_clear) begin
        cnt   <= '0;
        timer <= '0;
      end else if (i_run) begin
        if (rise_c) begin
          timer <= '0;
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end else if (timer != TIMER_MAX) begin
          timer <= timer + TIMER_W'(1);
        end
      end
    end
  end

  // compare against target-1 so the last edge ends the entry without a wrap
  assign o_hit_c     = i_run & rise_c & (cnt == (i_target - CNT_W'(1)));
  assign o_timeout_c = i_run & ~rise_c & (timer == TIMER_MAX);

endmodule

// File: rtl/sqwave_seq_ctrl.sv
// Table-driven sequencer that steps square_wave_gen through {m, n, periods} entries.
module sqwave_seq_ctrl
  import sqwave_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sqwave_seq_ctrl_if.slave   bus
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

  entry_t          tbl [DEPTH];
  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [MN_W-1:0] m_q, m_nxt, n_q, n_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            err_q, err_nxt;
  logic            applied, applied_nxt;
  logic            clear_c, run_c, hit_c, timeout_c;
  logic            advance_c, last_c, restart_c;
  entry_t          cur_c;

  assign cur_c     = tbl[idx];
  assign run_c     = (state == RUN);
  assign last_c    = (idx == LAST_IDX);
  assign restart_c = applied & bus.i_loop;
  assign advance_c = ((state == LOAD) && (cur_c.cnt == '0)) ||
                     (run_c && (hit_c || timeout_c));

  sqwave_period_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_period_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (clear_c),
    .i_run       (run_c),
    .i_q         (bus.i_q),
    .i_target    (cur_c.cnt),
    .o_hit_c     (hit_c),
    .o_timeout_c (timeout_c)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.i_start && !bus.i_stop) state_nxt = LOAD;
      LOAD, RUN: begin
        if (bus.i_stop)                  state_nxt = IDLE;
        else if (advance_c)              state_nxt = (!last_c || restart_c) ? LOAD : DONE;
        else if (state == LOAD)          state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of registered outputs and pass bookkeeping
  always_comb begin
    idx_nxt     = idx;
    m_nxt       = m_q;
    n_nxt       = n_q;
    err_nxt     = err_q;
    applied_nxt = applied;
    done_nxt    = 1'b0;
    clear_c     = 1'b0;
    busy_nxt    = (state_nxt == LOAD) || (state_nxt == RUN);
    case (state)
      IDLE: begin
        m_nxt = '0;
        n_nxt = '0;
        if (bus.i_start && !bus.i_stop) begin
          idx_nxt     = '0;
          err_nxt     = 1'b0;
          applied_nxt = 1'b0;
        end
      end
      LOAD, RUN: begin
        if (bus.i_stop) begin
          m_nxt = '0;
          n_nxt = '0;
        end else if (advance_c) begin
          if (run_c && timeout_c) err_nxt = 1'b1;
          if (!last_c) begin
            idx_nxt = idx + AW'(1);
          end else if (restart_c) begin
            idx_nxt     = '0;
            applied_nxt = 1'b0;
          end else begin
            done_nxt = 1'b1;
            if (!applied) err_nxt = 1'b1;
          end
        end else if (state == LOAD) begin
          m_nxt       = cur_c.m;
          n_nxt       = cur_c.n;
          applied_nxt = 1'b1;
          clear_c     = 1'b1;
        end
      end
      DONE: begin
        m_nxt = '0;
        n_nxt = '0;
      end
      default: begin
        m_nxt = '0;
        n_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      applied <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      m_q     <= m_nxt;
      n_q     <= n_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      applied <= applied_nxt;
    end
  end

  // Table writes are locked out while a sequence is running
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (bus.i_wr_en && !busy_q) begin
      tbl[bus.i_wr_addr] <= '{m: bus.i_wr_m, n: bus.i_wr_n, cnt: bus.i_wr_cnt};
    end
  end

  assign bus.o_m    = m_q;
  assign bus.o_n    = n_q;
  assign bus.o_busy = busy_q;
  assign bus.o_idx  = idx;
  assign bus.o_done = done_q;
  assign bus.o_err  = err_q;

endmodule
